byte_unstripe_rx: RTL and testbench

BYTE_UNSTRIPE_RX -- requirements
Module: byte_unstripe_rx

---
 rtl/byte_unstripe_rx_pkg.sv | 21 ++
 rtl/lane_mux.sv | 31 +++
 rtl/byte_unstripe_rx.sv | 138 +++++++++++++
 tb/tb_byte_unstripe_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_unstripe_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_unstripe_rx_pkg
//  Description : Shared definitions for the byte striping RX/TX pair:
//                FSM state encodings and default lane geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_unstripe_rx_pkg;

    // Default lane geometry used by both the striping TX and unstriping RX.
    localparam int BS_DEF_LANES = 4;
    localparam int BS_DEF_WIDTH = 8;

    // IDLE: no beat held. SERIAL: a beat is held and being serialized.
    typedef enum logic [0:0] {
        BS_IDLE   = 1'b0,
        BS_SERIAL = 1'b1
    } bs_state_e;

endpackage : byte_unstripe_rx_pkg
`default_nettype wire

// File: rtl/lane_mux.sv
`default_nettype none
// ============================================================================
//  Module      : lane_mux
//  Description : Combinational selection of one WIDTH-bit lane word out of a
//                flattened LANES*WIDTH vector, addressed by lane index.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_mux
    import byte_unstripe_rx_pkg::*;
#(
    parameter  int LANES = BS_DEF_LANES,
    parameter  int WIDTH = BS_DEF_WIDTH,
    localparam int LW    = $clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic [LW-1:0]          sel_i,
    output logic [WIDTH-1:0]       data_o
);

    logic [WIDTH-1:0] w_lanes [LANES];

    // Unpack the flat vector so lane k sits at bits [k*WIDTH +: WIDTH].
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lanes[k] = data_i[k*WIDTH +: WIDTH];
    end

    // LANES is a power of two, so every sel_i value addresses a real lane.
    assign data_o = w_lanes[sel_i];

endmodule : lane_mux
`default_nettype wire

// File: rtl/byte_unstripe_rx.sv
`default_nettype none
// ============================================================================
//  Module      : byte_unstripe_rx
//  Description : Captures one striped beat (LANES words) and serializes the
//                active lanes onto a single WIDTH-bit valid/ready stream,
//                lane 0 first. Back-to-back beats stream without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_unstripe_rx
    import byte_unstripe_rx_pkg::*;
#(
    parameter  int LANES = BS_DEF_LANES,
    parameter  int WIDTH = BS_DEF_WIDTH,
    localparam int LW    = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LW-1:0]          lanes_active,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic                   last_out,
    output logic                   busy
);

    bs_state_e              state_q, state_d;
    logic [LW-1:0]          idx_q, idx_d;
    logic [LANES*WIDTH-1:0] hold_data_q, hold_data_d;
    logic [LW-1:0]          hold_la_q, hold_la_d;

    logic                   w_accept;
    logic                   w_take;
    logic [WIDTH-1:0]       w_lane_word;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. ready_in in SERIAL is a pass-through
    // of the last-word handshake so a new beat lands on the same edge the
    // final word leaves, giving one word per cycle across beats.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        ready_in  = 1'b1;
        w_accept  = 1'b0;
        w_take    = 1'b0;

        busy      = (state_q == BS_SERIAL);
        valid_out = busy;
        last_out  = busy && (idx_q == hold_la_q);
        ready_in  = busy ? (valid_out & ready_out & last_out) : 1'b1;
        w_accept  = valid_in & ready_in;
        w_take    = valid_out & ready_out;

        case (state_q)
            BS_IDLE: begin
                if (w_accept) begin
                    state_d = BS_SERIAL;
                end
            end
            BS_SERIAL: begin
                if (w_take && last_out && !w_accept) begin
                    state_d = BS_IDLE;
                end
            end
            default: begin
                state_d = BS_IDLE;
            end
        endcase
    end

    // Lane index: restarts at 0 on capture, advances only when a word is
    // taken, and returns to 0 once the last word leaves.
    always_comb begin
        idx_d = idx_q;
        if (w_accept) begin
            idx_d = '0;
        end else if (w_take) begin
            idx_d = last_out ? '0 : idx_q + LW'(1);
        end
    end

    // Lane index register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Holding registers load only on acceptance, so later lanes_active or
    // data_in changes cannot disturb the beat being serialized.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_la_d   = hold_la_q;
        if (w_accept) begin
            hold_data_d = data_in;
            hold_la_d   = lanes_active;
        end
    end

    // Holding register group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data_q <= '0;
            hold_la_q   <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_la_q   <= hold_la_d;
        end
    end

    lane_mux #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_lane_mux (
        .data_i (hold_data_q),
        .sel_i  (idx_q),
        .data_o (w_lane_word)
    );

    // Drive zero when nothing is held so stale lanes never reach the bus.
    assign data_out = busy ? w_lane_word : '0;

endmodule : byte_unstripe_rx
`default_nettype wire

// File: tb/tb_byte_unstripe_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_unstripe_rx
//  Description : Directed self-checking bench for byte_unstripe_rx
//                (4x8 and 8x16 configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_unstripe_rx;

    logic         clk;
    logic         reset;

    // 4 lanes x 8 bits
    logic         v4, ri4, vo4, ro4, lo4, b4;
    logic [31:0]  data4;
    logic [1:0]   la4;
    logic [7:0]   do4;

    // 8 lanes x 16 bits
    logic         v8, ri8, vo8, ro8, lo8, b8;
    logic [127:0] data8;
    logic [2:0]   la8;
    logic [15:0]  do8;

    int errors;
    int checks;

    byte_unstripe_rx #(.LANES(4), .WIDTH(8)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (v4),
        .ready_in     (ri4),
        .data_in      (data4),
        .lanes_active (la4),
        .data_out     (do4),
        .valid_out    (vo4),
        .ready_out    (ro4),
        .last_out     (lo4),
        .busy         (b4)
    );

    byte_unstripe_rx #(.LANES(8), .WIDTH(16)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (v8),
        .ready_in     (ri8),
        .data_in      (data8),
        .lanes_active (la8),
        .data_out     (do8),
        .valid_out    (vo8),
        .ready_out    (ro8),
        .last_out     (lo8),
        .busy         (b8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0]  exp_a [4];
    logic [7:0]  exp_bb [8];
    logic [7:0]  exp_c [4];
    logic [7:0]  exp_r [4];
    logic [15:0] exp16;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        v4 = 1'b0; data4 = '0; la4 = '0; ro4 = 1'b0;
        v8 = 1'b0; data8 = '0; la8 = '0; ro8 = 1'b0;
        exp_a  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_bb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        exp_c  = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_r  = '{8'h10, 8'h11, 8'h12, 8'h13};

        // ---- Reset state ----
        #3;
        chk("rst_valid_out", vo4, 1'b0);
        chk("rst_busy", b4, 1'b0);
        chk("rst_data_out", do4, 8'h00);
        chk("rst_last_out", lo4, 1'b0);
        chk("rst_valid_out8", vo8, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_ready_in", ri4, 1'b1);

        // ---- Single beat, 4 lanes, ready_out high ----
        v4 = 1'b1; data4 = 32'h44332211; la4 = 2'd3; ro4 = 1'b1;
        #1;
        chk("t1_ready_idle", ri4, 1'b1);
        tick();
        v4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_valid", vo4, 1'b1);
            chk("t1_busy", b4, 1'b1);
            chk("t1_data", do4, exp_a[i]);
            chk("t1_last", lo4, (i == 3));
            chk("t1_ready_in", ri4, (i == 3));
            tick();
        end
        #1;
        chk("t1_idle_valid", vo4, 1'b0);
        chk("t1_idle_busy", b4, 1'b0);
        tick();

        // ---- Two beats back-to-back ----
        v4 = 1'b1; data4 = 32'hA4A3A2A1; la4 = 2'd3; ro4 = 1'b1;
        tick();
        data4 = 32'hB4B3B2B1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) v4 = 1'b0;
            #1;
            chk("t2_valid", vo4, 1'b1);
            chk("t2_data", do4, exp_bb[i]);
            chk("t2_last", lo4, (i % 4 == 3));
            chk("t2_ready_in", ri4, (i % 4 == 3));
            tick();
        end
        #1;
        chk("t2_idle_valid", vo4, 1'b0);
        tick();

        // ---- lanes_active=1 with stalls ----
        v4 = 1'b1; data4 = 32'hDDCCBBAA; la4 = 2'd1; ro4 = 1'b1;
        tick();
        v4 = 1'b0;
        ro4 = 1'b1; #1;
        chk("t3_w0_data", do4, 8'hAA);
        chk("t3_w0_last", lo4, 1'b0);
        tick();
        ro4 = 1'b0; #1;
        chk("t3_s1_data", do4, 8'hBB);
        chk("t3_s1_last", lo4, 1'b1);
        chk("t3_s1_ready_in", ri4, 1'b0);
        tick();
        ro4 = 1'b0; #1;
        chk("t3_s2_valid", vo4, 1'b1);
        chk("t3_s2_data", do4, 8'hBB);
        chk("t3_s2_last", lo4, 1'b1);
        tick();
        ro4 = 1'b1; #1;
        chk("t3_w1_data", do4, 8'hBB);
        chk("t3_w1_ready_in", ri4, 1'b1);
        tick();
        #1;
        chk("t3_idle_valid", vo4, 1'b0);
        chk("t3_idle_data", do4, 8'h00);

        // ---- lanes_active changes after acceptance ----
        v4 = 1'b1; data4 = 32'h04030201; la4 = 2'd3; ro4 = 1'b1;
        tick();
        v4 = 1'b0; la4 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_valid", vo4, 1'b1);
            chk("t4_data", do4, exp_c[i]);
            chk("t4_last", lo4, (i == 3));
            tick();
        end
        #1;
        chk("t4_idle_valid", vo4, 1'b0);
        v4 = 1'b1; data4 = 32'h5A5A5AE5; la4 = 2'd0;
        tick();
        v4 = 1'b0;
        #1;
        chk("t4_one_data", do4, 8'hE5);
        chk("t4_one_last", lo4, 1'b1);
        chk("t4_one_ready_in", ri4, 1'b1);
        tick();
        #1;
        chk("t4_one_idle", vo4, 1'b0);

        // ---- Reset in the middle of a beat ----
        v4 = 1'b1; data4 = 32'h8F8E8D8C; la4 = 2'd3; ro4 = 1'b1;
        tick();
        v4 = 1'b0;
        #1;
        chk("t5_w0_data", do4, 8'h8C);
        tick();
        #1;
        chk("t5_w1_data", do4, 8'h8D);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", vo4, 1'b0);
        chk("t5_rst_busy", b4, 1'b0);
        chk("t5_rst_data", do4, 8'h00);
        chk("t5_rst_last", lo4, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rel_ready_in", ri4, 1'b1);
        chk("t5_rel_valid", vo4, 1'b0);
        tick();
        #1;
        chk("t5_rel_still_idle", vo4, 1'b0);
        v4 = 1'b1; data4 = 32'h13121110; la4 = 2'd3;
        tick();
        v4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_new_data", do4, exp_r[i]);
            chk("t5_new_last", lo4, (i == 3));
            tick();
        end
        #1;
        chk("t5_new_idle", vo4, 1'b0);

        // ---- 8 lanes x 16 bits ----
        v8 = 1'b1; la8 = 3'd7; ro8 = 1'b1;
        data8 = {16'h8888, 16'h7777, 16'h6666, 16'h5555,
                 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #1;
        chk("t6_ready_idle", ri8, 1'b1);
        tick();
        v8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp16 = 16'(16'h1111 * (i + 1));
            #1;
            chk("t6_valid", vo8, 1'b1);
            chk("t6_data", do8, exp16);
            chk("t6_last", lo8, (i == 7));
            tick();
        end
        #1;
        chk("t6_idle_valid", vo8, 1'b0);
        chk("t6_idle_busy", b8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_byte_unstripe_rx
`default_nettype wire
